// File: rtl/lru_replacement_unit_pkg.sv
// Shared types and age-update functions for the per-set true-LRU tracker.
// Each set keeps a permutation of ages. Age 0 is the MRU way and LRU_WAYS-1 is the LRU way.
package lru_replacement_pkg;

  localparam int LRU_SA   = 2;
  localparam int LRU_WAYS = 1 << LRU_SA;

  typedef logic [LRU_SA-1:0]   way_t;
  // ages[i] holds the age of way i
  typedef way_t [LRU_WAYS-1:0] ages_t;

  localparam way_t LRU_AGE = way_t'(LRU_WAYS - 1);

  function automatic ages_t reset_ages();
    ages_t a;
    for (int i = 0; i < LRU_WAYS; i++) begin
      a[i] = way_t'(i);
    end
    return a;
  endfunction

  localparam ages_t RESET_AGES = reset_ages();

  function automatic ages_t access_update(ages_t ages, way_t way);
    ages_t n;
    way_t  old_age;
    old_age = ages[way];
    for (int i = 0; i < LRU_WAYS; i++) begin
      if (way_t'(i) == way) begin
        n[i] = '0;
      end else if (ages[i] < old_age) begin
        n[i] = ages[i] + 1'b1;
      end else begin
        n[i] = ages[i];
      end
    end
    return n;
  endfunction

  function automatic ages_t demote_update(ages_t ages, way_t way);
    ages_t n;
    way_t  old_age;
    old_age = ages[way];
    for (int i = 0; i < LRU_WAYS; i++) begin
      if (way_t'(i) == way) begin
        n[i] = LRU_AGE;
      end else if (ages[i] > old_age) begin
        n[i] = ages[i] - 1'b1;
      end else begin
        n[i] = ages[i];
      end
    end
    return n;
  endfunction

  function automatic way_t lru_way(ages_t ages);
    way_t w;
    w = '0;
    for (int i = 0; i < LRU_WAYS; i++) begin
      if (ages[i] == LRU_AGE) begin
        w = way_t'(i);
      end
    end
    return w;
  endfunction

  function automatic logic is_permutation(ages_t ages);
    logic [LRU_WAYS-1:0] seen;
    seen = '0;
    for (int i = 0; i < LRU_WAYS; i++) begin
      seen[ages[i]] = 1'b1;
    end
    return &seen;
  endfunction

endpackage

// File: rtl/lru_replacement_unit_if.sv
// Event and lookup bundle between the cache unit or controller and the LRU tracker.
// The master modport drives events and lookups. The slave modport belongs to the tracker.
interface lru_replacement_unit_if #(
  parameter int INDEX_WIDTH       = 6,
  parameter int SET_ASSOCIATIVITY = 2
);
  logic                         accessEnable;
  logic [INDEX_WIDTH-1:0]       accessIndex;
  logic [SET_ASSOCIATIVITY-1:0] accessWay;
  logic                         invalidateEnable;
  logic [INDEX_WIDTH-1:0]       invalidateIndex;
  logic [SET_ASSOCIATIVITY-1:0] invalidateWay;
  logic [INDEX_WIDTH-1:0]       lookupIndex;
  logic [SET_ASSOCIATIVITY-1:0] victimWay;

  modport master (
    output accessEnable, accessIndex, accessWay,
    output invalidateEnable, invalidateIndex, invalidateWay,
    output lookupIndex,
    input  victimWay
  );

  modport slave (
    input  accessEnable, accessIndex, accessWay,
    input  invalidateEnable, invalidateIndex, invalidateWay,
    input  lookupIndex,
    output victimWay
  );
endinterface

// File: rtl/lru_replacement_unit_set_state.sv
// Age state of one set, with access and invalidate updates and the LRU-way decode.
// If LRU_INVALIDATE_DEMOTE_EN is defined, invalidates demote the way to LRU. Otherwise they are ignored.
module lru_set_state
  import lru_replacement_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic access_en,
  input  way_t access_way,
  input  logic invalidate_en,
  input  way_t invalidate_way,
  output way_t victim_way
);

  ages_t ages_reg;
  ages_t ages_next;

  // An access has priority, so a same-set invalidate in that cycle is dropped
  always_comb begin
    ages_next = ages_reg;
    if (access_en) begin
      ages_next = access_update(ages_reg, access_way);
    end
`ifdef LRU_INVALIDATE_DEMOTE_EN
    else if (invalidate_en) begin
      ages_next = demote_update(ages_reg, invalidate_way);
    end
`endif
  end

`ifndef LRU_INVALIDATE_DEMOTE_EN
  logic unused_invalidate;
  assign unused_invalidate = invalidate_en ^ (^invalidate_way);
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ages_reg <= RESET_AGES;
    end else begin
      ages_reg <= ages_next;
    end
  end

  assign victim_way = lru_way(ages_reg);

  ages_perm_a: assert property (@(posedge clock) disable iff (reset) is_permutation(ages_reg));

endmodule

// File: rtl/lru_replacement_unit.sv
// Per-set true-LRU tracker. Each set has one age permutation, and victimWay is the LRU way of lookupIndex.
// The optional feature LRU_INVALIDATE_DEMOTE_EN demotes invalidated ways to LRU.
module lru_replacement_unit
  import lru_replacement_pkg::*;
#(
  parameter int INDEX_WIDTH       = 6,
  parameter int SET_ASSOCIATIVITY = LRU_SA
) (
  input logic                  clock,
  input logic                  reset,
  lru_replacement_unit_if.slave bus
);

  localparam int SETS = 1 << INDEX_WIDTH;

  logic [SET_ASSOCIATIVITY-1:0] victim_ways [SETS];

  generate
    for (genvar gi = 0; gi < SETS; gi++) begin : g_set
      logic access_hit;
      logic invalidate_hit;

      assign access_hit     = bus.accessEnable     && (bus.accessIndex     == INDEX_WIDTH'(gi));
      assign invalidate_hit = bus.invalidateEnable && (bus.invalidateIndex == INDEX_WIDTH'(gi));

      lru_set_state u_set (
        .clock          (clock),
        .reset          (reset),
        .access_en      (access_hit),
        .access_way     (bus.accessWay),
        .invalidate_en  (invalidate_hit),
        .invalidate_way (bus.invalidateWay),
        .victim_way     (victim_ways[gi])
      );
    end
  endgenerate

  // The victim is decoded from registered state only, with no bypass of this cycle's events
  assign bus.victimWay = victim_ways[bus.lookupIndex];

endmodule

// File: tb/tb_lru_replacement_unit.sv
// Directed scoreboard bench for lru_replacement_unit with 64 sets and 4 ways.
// The stimulus process queues the expected victims, and the monitor compares them on the falling edge.
module tb_lru_replacement_unit;

  logic clock;
  logic reset;

  lru_replacement_unit_if #(.INDEX_WIDTH(6), .SET_ASSOCIATIVITY(2)) bus ();

  lru_replacement_unit #(.INDEX_WIDTH(6), .SET_ASSOCIATIVITY(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [5:0] idx_q  [$];
  logic [1:0] exp_q  [$];
  string      name_q [$];

  int vectors;
  int miscompares;

`ifdef LRU_INVALIDATE_DEMOTE_EN
  localparam bit DEMOTE = 1'b1;
`else
  localparam bit DEMOTE = 1'b0;
`endif

  // Monitor
  initial begin
    logic [5:0] e_idx;
    logic [1:0] e_way;
    string      e_name;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e_idx  = idx_q.pop_front();
        e_way  = exp_q.pop_front();
        e_name = name_q.pop_front();
        vectors++;
        if (bus.lookupIndex !== e_idx || bus.victimWay !== e_way) begin
          miscompares++;
          $display("FAIL %s: lookupIndex=%0d victimWay=%0d, expected lookupIndex=%0d victimWay=%0d",
                   e_name, bus.lookupIndex, bus.victimWay, e_idx, e_way);
        end else begin
          $display("ok   %s: set %0d victimWay=%0d", e_name, e_idx, bus.victimWay);
        end
      end
    end
  end

  task automatic check(input logic [5:0] idx, input logic [1:0] way, input string name);
    bus.lookupIndex = idx;
    idx_q.push_back(idx);
    exp_q.push_back(way);
    name_q.push_back(name);
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic ae, input logic [5:0] ai, input logic [1:0] aw,
                       input logic ie, input logic [5:0] ii, input logic [1:0] iw);
    bus.accessEnable     = ae;
    bus.accessIndex      = ai;
    bus.accessWay        = aw;
    bus.invalidateEnable = ie;
    bus.invalidateIndex  = ii;
    bus.invalidateWay    = iw;
    @(posedge clock);
    #1;
    bus.accessEnable     = 1'b0;
    bus.invalidateEnable = 1'b0;
  endtask

  task automatic access(input logic [5:0] s, input logic [1:0] w);
    drive(1'b1, s, w, 1'b0, 6'd0, 2'd0);
  endtask

  task automatic invalidate(input logic [5:0] s, input logic [1:0] w);
    drive(1'b0, 6'd0, 2'd0, 1'b1, s, w);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.accessEnable     = 1'b0;
    bus.accessIndex      = '0;
    bus.accessWay        = '0;
    bus.invalidateEnable = 1'b0;
    bus.invalidateIndex  = '0;
    bus.invalidateWay    = '0;
    bus.lookupIndex      = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check(6'd0,  2'd3, "reset_set0");
    check(6'd63, 2'd3, "reset_set63");

    // An access to set 5 way 3 gives ages 1,2,3,0
    access(6'd5, 2'd3);
    check(6'd5, 2'd2, "acc5w3");
    check(6'd6, 2'd3, "set6_untouched");

    // An access to the MRU way is a no-op. Then ways 3, 2 and 1 are accessed.
    reset_pulse();
    access(6'd5, 2'd0);
    check(6'd5, 2'd3, "acc_mru_noop");
    access(6'd5, 2'd3);
    access(6'd5, 2'd2);
    access(6'd5, 2'd1);
    check(6'd5, 2'd0, "acc_seq_321");

    // Invalidates
    reset_pulse();
    invalidate(6'd9, 2'd0);
    check(6'd9, DEMOTE ? 2'd0 : 2'd3, "inv9w0");
    invalidate(6'd9, 2'd1);
    check(6'd9, DEMOTE ? 2'd1 : 2'd3, "inv9w1");
    invalidate(6'd10, 2'd3);
    check(6'd10, 2'd3, "inv_lru_noop");

    // Same-cycle collisions
    reset_pulse();
    drive(1'b1, 6'd4, 2'd3, 1'b1, 6'd4, 2'd1);
    check(6'd4, 2'd2, "same_set_access_wins");
    drive(1'b1, 6'd4, 2'd3, 1'b1, 6'd7, 2'd0);
    check(6'd4, 2'd2, "diff_set_access");
    check(6'd7, DEMOTE ? 2'd0 : 2'd3, "diff_set_inval");

    // No bypass: an access in the same cycle is not yet visible
    bus.accessEnable = 1'b1;
    bus.accessIndex  = 6'd4;
    bus.accessWay    = 2'd2;
    check(6'd4, 2'd2, "no_bypass");
    bus.accessEnable = 1'b0;
    check(6'd4, 2'd1, "after_acc4w2");

    // Back-to-back accesses, then a reset in the middle of the sequence
    reset_pulse();
    bus.accessEnable = 1'b1;
    bus.accessIndex  = 6'd2;
    bus.accessWay    = 2'd3;
    @(posedge clock);
    #1;
    bus.accessWay    = 2'd2;
    @(posedge clock);
    #1;
    bus.accessEnable = 1'b0;
    check(6'd2, 2'd1, "b2b_acc_3_2");
    reset = 1'b1;
    bus.accessEnable = 1'b1;
    bus.accessIndex  = 6'd2;
    bus.accessWay    = 2'd3;
    check(6'd2, 2'd3, "reset_immediate");
    bus.accessEnable = 1'b0;
    reset = 1'b0;
    check(6'd2, 2'd3, "enable_in_reset_ignored");
    access(6'd2, 2'd3);
    check(6'd2, 2'd2, "first_update_after_reset");

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge clock);
    end
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
